// File: rtl/rgb_pkg.sv
// Shared constants, state type and auto-cycle helper for the RGB mode controller.
package rgb_pkg;

   localparam logic [7:0] SC_R     = 8'h2D;
   localparam logic [7:0] SC_G     = 8'h34;
   localparam logic [7:0] SC_B     = 8'h32;
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_K     = 8'h42;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;

   localparam logic [2:0] COL_RED   = 3'b100;
   localparam logic [2:0] COL_GREEN = 3'b010;
   localparam logic [2:0] COL_BLUE  = 3'b001;
   localparam logic [2:0] COL_WHITE = 3'b000;
   localparam logic [2:0] COL_BLINK = 3'b111;

   typedef enum logic {MANUAL, AUTO} state_t;

   // Auto sequence red->green->blue->white->red; anything else restarts at red.
   function automatic logic [2:0] next_auto_colour(input logic [2:0] col);
      logic [2:0] nxt;
      case (col)
         COL_RED:   nxt = COL_GREEN;
         COL_GREEN: nxt = COL_BLUE;
         COL_BLUE:  nxt = COL_WHITE;
         default:   nxt = COL_RED;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/rgb_mode_ctrl_tick_gen.sv
// Free-running prescaler: registered one-cycle tick after every DIV clocks.
module tick_gen #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == LAST) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CW'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/rgb_mode_ctrl.sv
// Scan-code decode, manual/auto colour FSM and frame-synchronous colour apply.
module rgb_mode_ctrl
   import rgb_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 25_000_000,
   parameter int unsigned BLINK_HZ    = 10,
   parameter int unsigned DWELL_TICKS = 20
) (
   input  logic       vga_clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [7:0] key_code,
   input  logic       frame_start,
   output logic [2:0] choise_RGB,
   output logic       tenH_clk,
   output logic       auto_active,
   output logic       update_pending
);

   localparam int unsigned DIV = CLK_HZ / BLINK_HZ;
   localparam int unsigned DW  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

   state_t        state, state_nxt;
   logic [2:0]    pending, pending_nxt;
   logic [2:0]    choise_nxt;
   logic [DW-1:0] dwell, dwell_nxt;
   logic          skip_next, skip_nxt;

   tick_gen #(.DIV(DIV)) u_tick (
      .clk   (vga_clk),
      .reset (reset),
      .tick  (tenH_clk)
   );

   // Frame apply uses the old pending; a key overrides a same-cycle dwell advance.
   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      dwell_nxt   = dwell;
      skip_nxt    = skip_next;
      choise_nxt  = choise_RGB;

      if (frame_start)
         choise_nxt = pending;

      if (state == AUTO && tenH_clk) begin
         if (dwell == DWELL_LAST) begin
            dwell_nxt   = '0;
            pending_nxt = next_auto_colour(pending);
         end else begin
            dwell_nxt = dwell + DW'(1);
         end
      end

      if (key_valid && key_code != SC_EXT) begin
         if (skip_next) begin
            skip_nxt = 1'b0;
         end else begin
            case (key_code)
               SC_BREAK: skip_nxt = 1'b1;
               SC_R, SC_G, SC_B, SC_W, SC_K: begin
                  state_nxt = MANUAL;
                  dwell_nxt = dwell;
                  case (key_code)
                     SC_R:    pending_nxt = COL_RED;
                     SC_G:    pending_nxt = COL_GREEN;
                     SC_B:    pending_nxt = COL_BLUE;
                     SC_W:    pending_nxt = COL_WHITE;
                     default: pending_nxt = COL_BLINK;
                  endcase
               end
               SC_A: begin
                  if (state == MANUAL) begin
                     state_nxt   = AUTO;
                     pending_nxt = COL_RED;
                     dwell_nxt   = '0;
                  end else begin
                     state_nxt   = MANUAL;
                     pending_nxt = pending;
                     dwell_nxt   = dwell;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         state          <= MANUAL;
         pending        <= COL_WHITE;
         dwell          <= '0;
         skip_next      <= 1'b0;
         choise_RGB     <= COL_WHITE;
         auto_active    <= 1'b0;
         update_pending <= 1'b0;
      end else begin
         state          <= state_nxt;
         pending        <= pending_nxt;
         dwell          <= dwell_nxt;
         skip_next      <= skip_nxt;
         choise_RGB     <= choise_nxt;
         auto_active    <= (state_nxt == AUTO);
         update_pending <= (pending_nxt != choise_nxt);
      end
   end

endmodule

// File: tb/tb_rgb_mode_ctrl.sv
// Scoreboard bench for rgb_mode_ctrl: queued colour changes, tick cadence and directed flag checks.
module tb_rgb_mode_ctrl;

   logic       vga_clk = 1'b0;
   logic       reset = 1'b0;
   logic       key_valid = 1'b0;
   logic [7:0] key_code = 8'h00;
   logic       frame_start = 1'b0;
   logic [2:0] choise_RGB;
   logic       tenH_clk;
   logic       auto_active;
   logic       update_pending;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   logic [2:0] exp_q[$];
   logic [2:0] last_col = 3'b000;

   rgb_mode_ctrl #(.CLK_HZ(100), .BLINK_HZ(10), .DWELL_TICKS(2)) dut (
      .vga_clk        (vga_clk),
      .reset          (reset),
      .key_valid      (key_valid),
      .key_code       (key_code),
      .frame_start    (frame_start),
      .choise_RGB     (choise_RGB),
      .tenH_clk       (tenH_clk),
      .auto_active    (auto_active),
      .update_pending (update_pending)
   );

   always #5 vga_clk = ~vga_clk;

   always @(posedge vga_clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Monitor: tick cadence every cycle, and every choise_RGB change against the queue.
   always @(negedge vga_clk) begin
      logic exp_tick;
      logic [2:0] e;
      exp_tick = (cyc != 0) && (cyc % 10 == 0);
      n_cmp++;
      if (tenH_clk !== exp_tick) begin
         n_bad++;
         $display("FAIL tick cyc=%0d: got %b want %b", cyc, tenH_clk, exp_tick);
      end
      if (choise_RGB !== last_col) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL colour_change: got unexpected %b (was %b)", choise_RGB, last_col);
         end else begin
            e = exp_q.pop_front();
            if (choise_RGB !== e) begin
               n_bad++;
               $display("FAIL colour_change: got %b want %b", choise_RGB, e);
            end
         end
         last_col = choise_RGB;
      end
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge vga_clk);
      #1;
   endtask

   task automatic send_key(input logic [7:0] code, input logic with_frame);
      key_valid   = 1'b1;
      key_code    = code;
      frame_start = with_frame;
      step(1);
      key_valid   = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      step(1);
      frame_start = 1'b0;
   endtask

   initial begin
      #1 reset = 1'b1;
      step(3);
      reset = 1'b0;
      chk("rst_choise", 8'(choise_RGB), 8'h00);
      chk("rst_tick", 8'(tenH_clk), 8'h00);
      chk("rst_auto", 8'(auto_active), 8'h00);
      chk("rst_upd", 8'(update_pending), 8'h00);

      // Free run: only tick activity expected.
      step(50);
      chk("idle_choise", 8'(choise_RGB), 8'h00);
      chk("idle_auto", 8'(auto_active), 8'h00);

      // Red key, applied only at the frame.
      exp_q.push_back(3'b100);
      send_key(8'h2D, 1'b0);
      chk("r_upd_set", 8'(update_pending), 8'h01);
      step(10);
      chk("r_upd_hold", 8'(update_pending), 8'h01);
      chk("r_choise_hold", 8'(choise_RGB), 8'h00);
      pulse_frame();
      chk("r_choise_apply", 8'(choise_RGB), 8'h04);
      chk("r_upd_clr", 8'(update_pending), 8'h00);

      // Green key coinciding with frame: old colour kept until the next frame.
      exp_q.push_back(3'b010);
      send_key(8'h34, 1'b1);
      chk("g_same_cycle", 8'(choise_RGB), 8'h04);
      chk("g_upd", 8'(update_pending), 8'h01);
      step(3);
      pulse_frame();
      chk("g_apply", 8'(choise_RGB), 8'h02);

      // Break prefix (with an ignored E0 in between) swallows the next byte.
      send_key(8'hF0, 1'b0);
      send_key(8'hE0, 1'b0);
      send_key(8'h32, 1'b0);
      chk("brk_no_upd", 8'(update_pending), 8'h00);
      exp_q.push_back(3'b001);
      send_key(8'h32, 1'b0);
      chk("b_upd", 8'(update_pending), 8'h01);
      pulse_frame();
      chk("b_apply", 8'(choise_RGB), 8'h01);

      // Auto mode: red then advance every two ticks, frames every 5 cycles.
      exp_q.push_back(3'b100);
      exp_q.push_back(3'b010);
      exp_q.push_back(3'b001);
      exp_q.push_back(3'b000);
      exp_q.push_back(3'b100);
      send_key(8'h1C, 1'b0);
      chk("auto_on", 8'(auto_active), 8'h01);
      for (int i = 0; i < 18; i++) begin
         pulse_frame();
         step(4);
      end
      chk("auto_seq_done", 8'(exp_q.size()), 8'h00);
      exp_q.push_back(3'b111);
      send_key(8'h42, 1'b0);
      chk("k_auto_off", 8'(auto_active), 8'h00);
      pulse_frame();
      chk("k_apply", 8'(choise_RGB), 8'h07);

      // Reset while AUTO with a pending update.
      send_key(8'h1C, 1'b0);
      chk("pre_rst_auto", 8'(auto_active), 8'h01);
      chk("pre_rst_upd", 8'(update_pending), 8'h01);
      exp_q.push_back(3'b000);
      reset = 1'b1;
      #1;
      chk("arst_choise", 8'(choise_RGB), 8'h00);
      chk("arst_tick", 8'(tenH_clk), 8'h00);
      chk("arst_auto", 8'(auto_active), 8'h00);
      chk("arst_upd", 8'(update_pending), 8'h00);
      step(3);
      reset = 1'b0;
      step(2);
      pulse_frame();
      step(3);
      chk("post_rst_choise", 8'(choise_RGB), 8'h00);
      chk("post_rst_upd", 8'(update_pending), 8'h00);
      chk("post_rst_auto", 8'(auto_active), 8'h00);
      step(1);
      chk("queue_empty", 8'(exp_q.size()), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
